ac1_seq_ctrl: RTL and testbench

//  Sequencer for the bit-serial activation accumulator (ac1): drives its w_en/s_en/cl_en so one

---
 rtl/ac1_seq_ctrl_pkg.sv | 16 +
 rtl/ac1_seq_ctrl_if.sv | 30 +++
 rtl/ac1_plane_cnt.sv | 37 +++
 rtl/ac1_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_ac1_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ac1_seq_ctrl_pkg.sv
// rtl/ac1_seq_ctrl_pkg.sv - shared types and default sizing for the ac1 sequencer
package ac1_seq_ctrl_pkg;

   localparam int AC1_M      = 16;
   localparam int AC1_PA     = 8;
   localparam int AC1_NV_W   = 8;
   localparam bit AC1_SIGNED = 1'b1;
   localparam int PW         = $clog2(AC1_PA);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/ac1_seq_ctrl_if.sv
// rtl/ac1_seq_ctrl_if.sv - job, plane handshake, ac1 enable and result signals of the sequencer
interface ac1_seq_ctrl_if #(
   parameter int NV_W = 8,
   parameter int PW   = 3
);
   logic            start;
   logic [NV_W-1:0] n_vec;
   logic            abort;
   logic            in_valid;
   logic            in_ready;
   logic            w_en;
   logic            s_en;
   logic            cl_en;
   logic            sgn_plane;
   logic [PW-1:0]   plane_idx;
   logic            out_valid;
   logic            out_ready;
   logic            busy;
   logic            done;

   modport master (
      output start, n_vec, abort, in_valid, out_ready,
      input  in_ready, w_en, s_en, cl_en, sgn_plane, plane_idx, out_valid, busy, done
   );

   modport slave (
      input  start, n_vec, abort, in_valid, out_ready,
      output in_ready, w_en, s_en, cl_en, sgn_plane, plane_idx, out_valid, busy, done
   );
endinterface

// File: rtl/ac1_plane_cnt.sv
// rtl/ac1_plane_cnt.sv - modulo-PA bit-plane counter with clear and wrap flag
import ac1_seq_ctrl_pkg::*;

module ac1_plane_cnt #(
   parameter int PA   = AC1_PA,
   parameter int PW_L = PW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inc_i,
   input  logic            clr_i,
   output logic [PW_L-1:0] idx_o,
   output logic            wrap_o
);
   logic [PW_L-1:0] idx_q;
   logic [PW_L-1:0] idx_d;

   assign wrap_o = inc_i && (idx_q == PW_L'(PA - 1));
   assign idx_o  = idx_q;

   always_comb begin
      idx_d = idx_q;
      if (clr_i) begin
         idx_d = '0;
      end else if (inc_i) begin
         idx_d = wrap_o ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end
endmodule

// File: rtl/ac1_seq_ctrl.sv
// rtl/ac1_seq_ctrl.sv - sequences ac1 enables over Pa planes per result for a job of n_vec results
import ac1_seq_ctrl_pkg::*;

module ac1_seq_ctrl #(
   parameter int M      = AC1_M,
   parameter int Pa     = AC1_PA,
   parameter int NV_W   = AC1_NV_W,
   parameter bit SIGNED = AC1_SIGNED
) (
   input logic           clk,
   input logic           rst_n,
   ac1_seq_ctrl_if.slave ctrl_if
);
   localparam int PW_L = $clog2(Pa);

   if (Pa < 2 || M < 1) begin : g_bad_param
      $error("ac1_seq_ctrl: Pa must be >= 2 and M >= 1");
   end

   state_t          state_q, state_d;
   logic [NV_W-1:0] n_vec_q, n_vec_d;
   logic [NV_W-1:0] vec_cnt_q, vec_cnt_d;
   logic            out_valid_q, out_valid_d;
   logic            done_q, done_d;

   logic [PW_L-1:0] plane_idx;
   logic            wrap;
   logic            in_ready;
   logic            acc;
   logic            take;
   logic            last_vec;

   // A pending result blocks new planes: the plane-0 load would overwrite it.
   assign in_ready = (state_q == RUN) && !ctrl_if.abort && !(out_valid_q && !ctrl_if.out_ready);
   assign acc      = ctrl_if.in_valid && in_ready;
   assign take     = out_valid_q && ctrl_if.out_ready;
   assign last_vec = (vec_cnt_q == n_vec_q - 1'b1);

   ac1_plane_cnt #(.PA(Pa), .PW_L(PW_L)) u_plane_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_i  (acc),
      .clr_i  (ctrl_if.abort || (state_q != RUN)),
      .idx_o  (plane_idx),
      .wrap_o (wrap)
   );

   always_comb begin
      state_d     = state_q;
      n_vec_d     = n_vec_q;
      vec_cnt_d   = vec_cnt_q;
      done_d      = 1'b0;
      out_valid_d = out_valid_q;

      // A new result landing on the handshake edge keeps out_valid up.
      if (wrap) begin
         out_valid_d = 1'b1;
      end else if (take) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (ctrl_if.start) begin
               if (ctrl_if.n_vec != '0) begin
                  n_vec_d   = ctrl_if.n_vec;
                  vec_cnt_d = '0;
                  state_d   = RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (wrap) begin
               vec_cnt_d = vec_cnt_q + 1'b1;
               if (last_vec) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (take) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (ctrl_if.abort) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         vec_cnt_d   = '0;
         done_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         n_vec_q     <= '0;
         vec_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_vec_q     <= n_vec_d;
         vec_cnt_q   <= vec_cnt_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign ctrl_if.in_ready  = in_ready;
   assign ctrl_if.w_en      = acc;
   assign ctrl_if.s_en      = acc;
   assign ctrl_if.cl_en     = acc && (plane_idx == '0);
   assign ctrl_if.sgn_plane = SIGNED && (state_q == RUN) && (plane_idx == PW_L'(Pa - 1));
   assign ctrl_if.plane_idx = plane_idx;
   assign ctrl_if.out_valid = out_valid_q;
   assign ctrl_if.busy      = (state_q != IDLE);
   assign ctrl_if.done      = done_q;
endmodule

// File: tb/tb_ac1_seq_ctrl.sv
// tb/tb_ac1_seq_ctrl.sv - self-checking bench for ac1_seq_ctrl (M=16, Pa=8, SIGNED=1)
module tb_ac1_seq_ctrl;

   typedef struct {
      logic        start;
      logic [7:0]  n_vec;
      logic        abort;
      logic        in_valid;
      logic        out_ready;
      logic [10:0] exp;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ac1_seq_ctrl_if #(.NV_W(8), .PW(3)) bus ();

   ac1_seq_ctrl #(.M(16), .Pa(8), .NV_W(8), .SIGNED(1'b1)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ctrl_if (bus)
   );

   int   checks   = 0;
   int   failures = 0;
   int   planes_q[$];
   int   exp_q[$];
   int   acc_m    = 0;
   int   k_m      = 0;
   int   mon_v;
   int   mon_e;
   vec_t tbl[$];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   function automatic logic [10:0] ex(input logic ir, input logic w, input logic s, input logic cl,
                                      input logic sg, input int idx, input logic ov,
                                      input logic bz, input logic dn);
      return {ir, w, s, cl, sg, 3'(idx), ov, bz, dn};
   endfunction

   function automatic logic [10:0] outs();
      return {bus.in_ready, bus.w_en, bus.s_en, bus.cl_en, bus.sgn_plane, bus.plane_idx,
              bus.out_valid, bus.busy, bus.done};
   endfunction

   function automatic vec_t mk(input logic st, input logic [7:0] nv, input logic ab,
                               input logic iv, input logic ordy, input logic [10:0] e);
      vec_t r;
      r.start = st; r.n_vec = nv; r.abort = ab; r.in_valid = iv; r.out_ready = ordy; r.exp = e;
      return r;
   endfunction

   task automatic chk_outs(input string name, input logic [10:0] exp);
      checks++;
      if (outs() !== exp) begin
         failures++;
         $display("FAIL %s outs got=%b exp=%b", name, outs(), exp);
      end
   endtask

   // Plane sums and the signed, LSB-first weighted result they must produce.
   task automatic push_job(input int nvec);
      for (int v = 0; v < nvec; v++) begin
         int e = 0;
         for (int p = 0; p < 8; p++) begin
            int val = int'($urandom_range(0, 16));
            planes_q.push_back(val);
            e += ((p == 7) ? -val : val) <<< p;
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_idle();
      bus.start = 1'b0; bus.n_vec = '0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
   endtask

   task automatic apply_table(input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk); #1;
         bus.start = tbl[i].start; bus.n_vec = tbl[i].n_vec; bus.abort = tbl[i].abort;
         bus.in_valid = tbl[i].in_valid; bus.out_ready = tbl[i].out_ready;
         @(negedge clk);
         chk_outs($sformatf("%s_row%0d", name, i), tbl[i].exp);
      end
      drive_idle();
   endtask

   task automatic start_job(input int nv);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.n_vec = 8'(nv); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Behavioural ac1 driven by the DUT enables; results checked at the handshake edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL sb_unexpected_result got=%0d", acc_m);
            end else begin
               mon_e = exp_q.pop_front();
               chk("sb_result", acc_m, mon_e);
            end
         end
         if (bus.w_en) begin
            if (planes_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL sb_no_plane got=w_en exp=idle");
            end else begin
               mon_v = planes_q.pop_front();
               if (bus.cl_en) begin
                  acc_m = 0; k_m = 0;
               end else begin
                  k_m++;
               end
               acc_m += (bus.sgn_plane ? -mon_v : mon_v) <<< k_m;
            end
         end
      end
   end

   initial begin
      int acc_n, first_acc, last_acc, hs_n, done_n, bp_cnt, stall_bad, gap, gap_bad, ov_at;
      int cl_pos[$];
      bit stall, resumed;
      drive_idle();

      // Reset state
      repeat (2) @(negedge clk);
      chk_outs("reset", 11'b0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Single-vector job, cycle by cycle
      push_job(1);
      tbl.delete();
      tbl.push_back(mk(1, 1, 0, 1, 1, ex(0,0,0,0,0,0,0,0,0)));
      tbl.push_back(mk(0, 0, 0, 1, 1, ex(1,1,1,1,0,0,0,1,0)));
      for (int p = 1; p < 7; p++) tbl.push_back(mk(0, 0, 0, 1, 1, ex(1,1,1,0,0,p,0,1,0)));
      tbl.push_back(mk(0, 0, 0, 1, 1, ex(1,1,1,0,1,7,0,1,0)));
      tbl.push_back(mk(0, 0, 0, 0, 1, ex(0,0,0,0,0,0,1,1,0)));
      tbl.push_back(mk(0, 0, 0, 0, 1, ex(0,0,0,0,0,0,0,0,1)));
      tbl.push_back(mk(0, 0, 0, 0, 1, ex(0,0,0,0,0,0,0,0,0)));
      apply_table("n1");
      chk("n1_sb_empty", exp_q.size(), 0);

      // Three back-to-back vectors at full throughput
      push_job(3);
      start_job(3);
      acc_n = 0; first_acc = -1; last_acc = -1; hs_n = 0; done_n = 0; cl_pos.delete();
      for (int cyc = 0; cyc < 40; cyc++) begin
         bus.in_valid = (planes_q.size() != 0);
         @(negedge clk);
         if (bus.w_en) begin
            acc_n++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            if (bus.cl_en) cl_pos.push_back(acc_n);
         end
         if (bus.out_valid && bus.out_ready) hs_n++;
         if (bus.done) begin
            done_n++;
            chk("n3_done_not_busy", int'(bus.busy), 0);
         end
         @(posedge clk); #1;
      end
      drive_idle();
      chk("n3_acc_count", acc_n, 24);
      chk("n3_acc_span", last_acc - first_acc + 1, 24);
      chk("n3_cl_count", cl_pos.size(), 3);
      if (cl_pos.size() == 3) begin
         chk("n3_cl_pos0", cl_pos[0], 1);
         chk("n3_cl_pos1", cl_pos[1], 9);
         chk("n3_cl_pos2", cl_pos[2], 17);
      end
      chk("n3_results", hs_n, 3);
      chk("n3_done", done_n, 1);

      // Backpressure: consumer stalls five cycles after the first result
      push_job(2);
      start_job(2);
      bp_cnt = 0; stall_bad = 0; resumed = 0; done_n = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         bus.in_valid = (planes_q.size() != 0);
         stall = bus.out_valid && (bp_cnt < 5);
         if (stall) bp_cnt++;
         bus.out_ready = !stall;
         @(negedge clk);
         if (stall && (bus.in_ready || bus.w_en || !bus.out_valid)) stall_bad++;
         if (!stall && !resumed && bp_cnt == 5) begin
            resumed = 1;
            chk("bp_resume_cl_w", int'({bus.cl_en, bus.w_en, bus.out_valid}), 7);
         end
         if (bus.done) done_n++;
         @(posedge clk); #1;
      end
      drive_idle();
      chk("bp_stall_cycles", bp_cnt, 5);
      chk("bp_stall_bad", stall_bad, 0);
      chk("bp_done", done_n, 1);
      chk("bp_sb_empty", exp_q.size(), 0);

      // in_valid gap over planes 3-4
      push_job(1);
      start_job(1);
      acc_n = 0; gap = 0; gap_bad = 0; ov_at = -1; done_n = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         stall = (acc_n == 3) && (gap < 2);
         if (stall) gap++;
         bus.in_valid = (planes_q.size() != 0) && !stall;
         @(negedge clk);
         if (stall && (bus.plane_idx != 3'd3 || bus.w_en || bus.s_en || bus.cl_en)) gap_bad++;
         if (bus.out_valid && ov_at < 0) ov_at = acc_n;
         if (bus.w_en) acc_n++;
         if (bus.done) done_n++;
         @(posedge clk); #1;
      end
      drive_idle();
      chk("gap_cycles", gap, 2);
      chk("gap_bad", gap_bad, 0);
      chk("gap_acc_before_result", ov_at, 8);
      chk("gap_done", done_n, 1);

      // Abort mid-vector, then an empty job
      push_job(2);
      tbl.delete();
      tbl.push_back(mk(1, 2, 0, 1, 1, ex(0,0,0,0,0,0,0,0,0)));
      tbl.push_back(mk(0, 0, 0, 1, 1, ex(1,1,1,1,0,0,0,1,0)));
      for (int p = 1; p < 4; p++) tbl.push_back(mk(0, 0, 0, 1, 1, ex(1,1,1,0,0,p,0,1,0)));
      tbl.push_back(mk(0, 0, 1, 1, 1, ex(0,0,0,0,0,4,0,1,0)));
      tbl.push_back(mk(0, 0, 0, 0, 1, ex(0,0,0,0,0,0,0,0,0)));
      tbl.push_back(mk(1, 0, 0, 0, 1, ex(0,0,0,0,0,0,0,0,0)));
      tbl.push_back(mk(0, 0, 0, 0, 1, ex(0,0,0,0,0,0,0,0,1)));
      tbl.push_back(mk(0, 0, 0, 0, 1, ex(0,0,0,0,0,0,0,0,0)));
      apply_table("abort");
      planes_q.delete(); exp_q.delete();

      // Asynchronous reset in the middle of a job
      push_job(2);
      start_job(2);
      bus.in_valid = 1'b1;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_outs("rst_mid_run", 11'b0);
      planes_q.delete(); exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk_outs("rst_release_idle", 11'b0);
      repeat (2) @(negedge clk);
      chk_outs("rst_stays_idle", 11'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
